if_fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer around the program counter. Owns the PC and steps it.

---
 rtl/if_fetch_ctrl_if.sv | 36 +++
 rtl/if_fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl_if
// Description : Byte-wide req/ack memory read port used by the fetch
//               sequencer. The master issues the request and address. The
//               slave (memory) answers with ack and one data byte.
//               Signals:
//                 mem_req   request, held with mem_addr until ack
//                 mem_addr  byte address
//                 mem_ack   byte returned this cycle
//                 mem_rdata returned byte
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the PC. Fetches each 32-bit
//               instruction as four little-endian byte reads and presents the
//               result and its PC to the decode stage. A jump from EX
//               overrides everything else in the cycle it is seen.
//               Ports:
//                 clk        rising-edge clock
//                 rst        asynchronous reset, active low
//                 stall      decode not ready; hold presented instruction
//                 jump       redirect request
//                 jump_addr  redirect target (low two bits ignored)
//                 mem        byte memory port (master side)
//                 pc         address of instruction being fetched
//                 if_valid   if_inst/if_pc hold a complete instruction
//                 if_pc      PC of if_inst
//                 if_inst    assembled instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    if_fetch_ctrl_if.master   mem,
    output logic [ADDR_W-1:0] pc,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [ADDR_W-1:0] c_align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_cnt;
    logic [23:0]       r_buf;
    logic              r_if_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_inst;

    logic              w_mem_req;
    logic              w_ack;
    logic              w_last;
    logic [ADDR_W-1:0] w_jump_pc;

    // Masking keeps every bit of jump_addr in use while word-aligning it.
    assign w_jump_pc = jump_addr & c_align_mask;
    // Ack outside S_REQ carries no meaning and is ignored.
    assign w_ack     = w_mem_req & mem.mem_ack;
    assign w_last    = w_ack & (r_cnt == 2'd3);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (jump) begin
            w_state_nxt = S_REQ;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_REQ;
                S_REQ:   if (w_last) w_state_nxt = S_HOLD;
                S_HOLD:  if (!stall) w_state_nxt = S_REQ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Decoded purely from state so an async reset drops the request at once.
    always_comb begin
        w_mem_req = (r_state == S_REQ);
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_pc + {{(ADDR_W-2){1'b0}}, r_cnt};

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_cnt      <= 2'd0;
            r_buf      <= 24'd0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= 32'd0;
        end else if (jump) begin
            // Any byte or completion arriving alongside a jump is dropped.
            r_pc       <= w_jump_pc;
            r_cnt      <= 2'd0;
            r_if_valid <= 1'b0;
        end else if (w_ack) begin
            case (r_cnt)
                2'd0:    r_buf[7:0]   <= mem.mem_rdata;
                2'd1:    r_buf[15:8]  <= mem.mem_rdata;
                2'd2:    r_buf[23:16] <= mem.mem_rdata;
                default: begin
                    r_if_inst  <= {mem.mem_rdata, r_buf};
                    r_if_pc    <= r_pc;
                    r_if_valid <= 1'b1;
                    r_pc       <= r_pc + {{(ADDR_W-3){1'b0}}, 3'd4};
                end
            endcase
            r_cnt <= r_cnt + 2'd1;
        end else if ((r_state == S_HOLD) && !stall) begin
            r_if_valid <= 1'b0;
        end
    end

    assign pc       = r_pc;
    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_ctrl
// Description : Directed self-checking bench for if_fetch_ctrl. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump;
    logic [31:0] jump_addr;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    if_fetch_ctrl_if #(.ADDR_W(32)) mem_if ();

    if_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem       (mem_if),
        .pc        (pc),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one byte: request must be up at exp_addr, stay stable for
    // wait_cyc cycles, then ack is given for one cycle.
    task automatic byte_xfer(input logic [31:0] exp_addr, input logic [7:0] d,
                             input int wait_cyc, input string tag);
        chk({tag, "_req"}, mem_if.mem_req, 1'b1);
        chk({tag, "_addr"}, mem_if.mem_addr, exp_addr);
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            chk({tag, "_req_hold"}, mem_if.mem_req, 1'b1);
            chk({tag, "_addr_hold"}, mem_if.mem_addr, exp_addr);
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = d;
        @(negedge clk);
        mem_if.mem_ack   = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        stall            = 1'b0;
        jump             = 1'b0;
        jump_addr        = 32'd0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'd0;

        // Reset state
        @(negedge clk);
        chk("rst_req", mem_if.mem_req, 1'b0);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);

        // Release: one idle cycle, then request at RESET_PC
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("idle_req", mem_if.mem_req, 1'b0);
        @(negedge clk);

        // 1. Basic fetch, ack one cycle after request
        byte_xfer(32'h0, 8'h13, 1, "t1_b0");
        byte_xfer(32'h1, 8'h05, 1, "t1_b1");
        byte_xfer(32'h2, 8'h10, 1, "t1_b2");
        stall = 1'b1;  // no effect in S_REQ; holds the result once presented
        byte_xfer(32'h3, 8'h00, 1, "t1_b3");
        chk("t1_valid", if_valid, 1'b1);
        chk("t1_inst", if_inst, 32'h0010_0513);
        chk("t1_if_pc", if_pc, 32'h0);
        chk("t1_pc", pc, 32'h4);
        chk("t1_req", mem_if.mem_req, 1'b0);

        // 2. Stall holds the instruction
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_valid", if_valid, 1'b1);
            chk("t2_inst", if_inst, 32'h0010_0513);
            chk("t2_req", mem_if.mem_req, 1'b0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("t2_valid_drop", if_valid, 1'b0);

        // 3. Jump while cnt==2 (same-cycle acks)
        byte_xfer(32'h4, 8'hAA, 0, "t3_b0");
        byte_xfer(32'h5, 8'hBB, 0, "t3_b1");
        chk("t3_addr_cnt2", mem_if.mem_addr, 32'h6);
        jump      = 1'b1;
        jump_addr = 32'h0000_0102;
        @(negedge clk);
        jump = 1'b0;
        chk("t3_req", mem_if.mem_req, 1'b1);
        chk("t3_addr", mem_if.mem_addr, 32'h100);
        chk("t3_pc", pc, 32'h100);
        chk("t3_valid", if_valid, 1'b0);

        // 4. Jump coincides with the 4th ack
        byte_xfer(32'h100, 8'h93, 0, "t4_b0");
        byte_xfer(32'h101, 8'h00, 0, "t4_b1");
        byte_xfer(32'h102, 8'h10, 0, "t4_b2");
        chk("t4_addr_b3", mem_if.mem_addr, 32'h103);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 8'h00;
        jump             = 1'b1;
        jump_addr        = 32'h0000_0200;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        jump           = 1'b0;
        chk("t4_valid", if_valid, 1'b0);
        chk("t4_req", mem_if.mem_req, 1'b1);
        chk("t4_addr", mem_if.mem_addr, 32'h200);
        chk("t4_if_pc_stale", if_pc, 32'h0);
        @(negedge clk);
        chk("t4_valid_later", if_valid, 1'b0);

        // 5. PC wrap at the top of the address space
        jump      = 1'b1;
        jump_addr = 32'hFFFF_FFFE;
        @(negedge clk);
        jump = 1'b0;
        byte_xfer(32'hFFFF_FFFC, 8'hB7, 0, "t5_b0");
        byte_xfer(32'hFFFF_FFFD, 8'h12, 1, "t5_b1");
        byte_xfer(32'hFFFF_FFFE, 8'h34, 0, "t5_b2");
        byte_xfer(32'hFFFF_FFFF, 8'h56, 1, "t5_b3");
        chk("t5_valid", if_valid, 1'b1);
        chk("t5_inst", if_inst, 32'h5634_12B7);
        chk("t5_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_pc", pc, 32'h0);
        @(negedge clk);
        chk("t5_next_addr", mem_if.mem_addr, 32'h0);
        chk("t5_valid_drop", if_valid, 1'b0);

        // 6. Asynchronous reset mid-fetch (cnt==1)
        jump      = 1'b1;
        jump_addr = 32'h0000_0040;
        @(negedge clk);
        jump = 1'b0;
        byte_xfer(32'h40, 8'h11, 0, "t6_b0");
        chk("t6_addr_cnt1", mem_if.mem_addr, 32'h41);
        rst = 1'b0;
        #1;
        chk("t6_req_async", mem_if.mem_req, 1'b0);
        chk("t6_valid_async", if_valid, 1'b0);
        chk("t6_pc_async", pc, 32'h0);
        chk("t6_addr_async", mem_if.mem_addr, 32'h0);
        chk("t6_if_pc_async", if_pc, 32'h0);
        chk("t6_if_inst_async", if_inst, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_idle_req", mem_if.mem_req, 1'b0);
        @(negedge clk);
        chk("t6_req", mem_if.mem_req, 1'b1);
        chk("t6_addr", mem_if.mem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
